// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 serial transmitter (transmit half of the board UART).
// Bytes pushed with a one-cycle TX_EN strobe are queued in a small FIFO and
// sent LSB-first on UART_TX, each bit held for BAUD_DIV sysclk cycles.
//
// Ports:
//   sysclk     system clock, all logic on the rising edge
//   reset      synchronous active-low reset
//   TX_EN      write strobe; pushes UART_TXD when the FIFO is not full
//   UART_TXD   byte to transmit
//   TX_STATUS  1 = FIFO not full, a write will be accepted
//   TX_BUSY    1 = frame on the line or FIFO non-empty
//   TX_OVF     sticky overflow: a write arrived while full and was dropped
//   TX_COUNT   bytes queued, excluding the frame in flight
//   UART_TX    registered serial line, idle high
//
// Optional feature macro UART_TX_PARITY_EN: adds an even-parity bit between
// the data bits and the stop bit (11-bit frame). Undefined: plain 8N1.
module uart_tx_fifo #(
  parameter int BAUD_DIV = 10417,
  parameter int FIFO_AW  = 2
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             TX_EN,
  input  logic [7:0]       UART_TXD,
  output logic             TX_STATUS,
  output logic             TX_BUSY,
  output logic             TX_OVF,
  output logic [FIFO_AW:0] TX_COUNT,
  output logic             UART_TX
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count_q;
  logic                 ovf_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic full, empty, baud_done, push, pop;

  // Full is judged on the registered count, so a push at DEPTH is dropped
  // even when a pop frees a slot on the same edge.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign baud_done = (baud_q == BAUD_LAST);
  assign push      = TX_EN && !full;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem[rd_ptr];
`endif
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_d = STOP;
          baud_d  = '0;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            shift_d = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem[rd_ptr];
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is computed for the next state so UART_TX is a plain flop.
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      if (TX_EN && full) ovf_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= UART_TXD;
  end

  assign TX_STATUS = !full;
  assign TX_BUSY   = (state_q != IDLE) || !empty;
  assign TX_OVF    = ovf_q;
  assign TX_COUNT  = count_q;
  assign UART_TX   = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int BAUD  = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * BAUD;

  logic          sysclk = 1'b0;
  logic          reset  = 1'b0;
  logic          tx_en  = 1'b0;
  logic [7:0]    txd    = 8'h00;
  logic          tx_status, tx_busy, tx_ovf, uart_tx;
  logic [AW:0]   tx_count;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.BAUD_DIV(BAUD), .FIFO_AW(AW)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .TX_EN     (tx_en),
    .UART_TXD  (txd),
    .TX_STATUS (tx_status),
    .TX_BUSY   (tx_busy),
    .TX_OVF    (tx_ovf),
    .TX_COUNT  (tx_count),
    .UART_TX   (uart_tx)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the frame currently on the line,
  // described as a bit vector and a cycle position within it.
  byte unsigned     mq[$];
  bit               m_in_frame = 1'b0;
  int               m_pos      = 0;
  bit               m_ovf      = 1'b0;
  logic [NBITS-1:0] m_frame    = '1;
  bit               m_full, m_can_pop;
  bit               chk_en     = 1'b0;

  function automatic logic [NBITS-1:0] build_frame(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  always @(posedge sysclk) begin
    if (!reset) begin
      mq.delete();
      m_in_frame = 1'b0;
      m_pos      = 0;
      m_ovf      = 1'b0;
    end else begin
      m_full    = (mq.size() == DEPTH);
      m_can_pop = (mq.size() > 0) && (!m_in_frame || m_pos == FL - 1);
      if (m_in_frame) begin
        if (m_pos == FL - 1) m_in_frame = 1'b0;
        else m_pos++;
      end
      if (m_can_pop) begin
        m_frame    = build_frame(mq.pop_front());
        m_in_frame = 1'b1;
        m_pos      = 0;
      end
      if (tx_en) begin
        if (m_full) m_ovf = 1'b1;
        else mq.push_back(txd);
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge sysclk) begin
    if (chk_en) begin
      check("uart_tx",   uart_tx,   m_in_frame ? m_frame[m_pos / BAUD] : 1'b1);
      check("tx_count",  tx_count,  mq.size());
      check("tx_status", tx_status, mq.size() < DEPTH);
      check("tx_busy",   tx_busy,   m_in_frame || (mq.size() != 0));
      check("tx_ovf",    tx_ovf,    m_ovf);
    end
  end

  task automatic push(input logic [7:0] b);
    tx_en = 1'b1;
    txd   = b;
    @(negedge sysclk);
    tx_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (tx_busy && n < limit);
    if (tx_busy) check("idle_timeout", 1, 0);
  endtask

  initial begin
    int n;
    int peak;
    int lows;
    logic [63:0] obs;

    repeat (3) @(negedge sysclk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_status",  tx_status, 1);
    check("rst_busy",    tx_busy, 0);
    check("rst_ovf",     tx_ovf, 0);
    check("rst_count",   tx_count, 0);
    reset = 1'b1;
    @(negedge sysclk);

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    @(negedge sysclk);
    check("start_low", uart_tx, 0);
    obs = '0;
    obs[0] = uart_tx;
    for (int j = 1; j < 44; j++) begin
      @(negedge sysclk);
      obs[j] = uart_tx;
    end
    check("frame_07_par", obs, 64'h0FF00000FFF0);
    check("busy_end_frame", tx_busy, 1);
    @(negedge sysclk);
    check("busy_after_44", tx_busy, 0);
`else
    push(8'hA5);
    @(negedge sysclk);
    check("start_low", uart_tx, 0);
    obs = '0;
    obs[0] = uart_tx;
    for (int j = 1; j < 40; j++) begin
      @(negedge sysclk);
      obs[j] = uart_tx;
    end
    check("frame_a5", obs, 64'hFF0F00F0F0);
    check("busy_end_frame", tx_busy, 1);
    @(negedge sysclk);
    check("busy_after_40", tx_busy, 0);
`endif

    // Three back-to-back frames
    @(negedge sysclk);
    peak = 0;
    push(8'h01);
    if (tx_count > peak) peak = tx_count;
    push(8'h02);
    if (tx_count > peak) peak = tx_count;
    push(8'h03);
    if (tx_count > peak) peak = tx_count;
    @(negedge sysclk);
    if (tx_count > peak) peak = tx_count;
    check("peak_count", peak, 2);
    wait_idle(500, n);
    check("three_frames_len", n + 1, 3 * FL - 1);

    // Overflow: six pushes, sixth dropped
    @(negedge sysclk);
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check("full_status", tx_status, 0);
    check("full_count",  tx_count, 4);
    push(8'h15);
    check("ovf_set",      tx_ovf, 1);
    check("ovf_count",    tx_count, 4);
    wait_idle(1000, n);
    check("five_frames_len", n, 5 * FL - 4);

    // Reset in the middle of data bit 3 with two bytes queued
    @(negedge sysclk);
    push(8'h3C);
    push(8'h5A);
    push(8'h99);
    check("queued_two", tx_count, 2);
    repeat (16) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    check("midrst_tx",    uart_tx, 1);
    check("midrst_count", tx_count, 0);
    check("midrst_ovf",   tx_ovf, 0);
    check("midrst_busy",  tx_busy, 0);
    reset = 1'b1;
    lows = 0;
    repeat (3 * FL) begin
      @(negedge sysclk);
      if (uart_tx == 1'b0) lows++;
    end
    check("no_frames_after_rst", lows, 0);

    // Push on the same edge as a pop while full
    for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
    check("full_before", tx_count, 4);
    n = 0;
    while (!(m_in_frame && m_pos == FL - 1) && n < 4 * FL) begin
      @(negedge sysclk);
      n++;
    end
    check("stop_last_reached", n, FL - 4);
    check("full_at_pop", tx_count, 4);
    push(8'hEE);
    check("pop_push_count",  tx_count, 3);
    check("pop_push_ovf",    tx_ovf, 1);
    check("pop_push_status", tx_status, 1);
    wait_idle(1000, n);
    check("remaining_frames_len", n, 4 * FL);

    repeat (2) @(negedge sysclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
